// File: rtl/rd_fwft_stage.sv
// First-word-fall-through adapter: turns a one-cycle-latency FIFO read port into a
// valid/ready stream through a two-entry (head, tail) skid buffer.
module rd_fwft_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;
  logic                  capture;
  logic [2:0]            demand;

  always_comb begin
    pop     = (state_q != EMPTY) && m_ready;
    capture = inflight_q && !flush;
    // Words already committed to the buffer after this cycle's pop; a new read
    // is only safe while that leaves room for the word it brings back.
    demand     = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_rd_en = !fifo_empty && !flush && rrst_n && (demand < 3'd2);
    inflight_d = fifo_rd_en;

    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (capture) begin
            head_d  = fifo_rdata;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({capture, pop})
            2'b10: begin
              tail_d  = fifo_rdata;
              state_d = TWO;
            end
            2'b01: state_d = EMPTY;
            2'b11: head_d = fifo_rdata;
            default: state_d = ONE;
          endcase
        end
        TWO: begin
          // No capture can arrive here without a pop: reads stop once two words are committed.
          if (pop) begin
            head_d = tail_q;
            if (capture) begin
              tail_d = fifo_rdata;
            end else begin
              state_d = ONE;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
    end
  end

  // Tail is never observable until it has been written, so it carries no reset.
  always_ff @(posedge rclk) begin
    tail_q <= tail_d;
  end

  assign m_valid   = (state_q != EMPTY);
  assign m_data    = head_q;
  assign occupancy = state_q;

endmodule
